// File: rtl/fusion_accumulator.sv
// fusion_accumulator: per-lane dot-product accumulation of fusion unit product words
module fusion_accumulator #(
    parameter int ACC_W = 32,
    parameter int LEN_W = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           cfga,
    input  logic [1:0]           cfgb,
    input  logic                 sgn,
    input  logic [LEN_W-1:0]     len,
    input  logic                 in_valid,
    input  logic [63:0]          in_data,
    output logic                 in_ready,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [4*ACC_W-1:0]   res_data,
    output logic [2:0]           res_lanes,
    output logic                 sat_flag,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t             state, state_next;
    logic [3:0]         cfg;
    logic               sgn_r, legal_r;
    logic [LEN_W-1:0]   len_r, cnt;
    logic [ACC_W-1:0]   acc [4];
    logic [ACC_W-1:0]   sum [4];
    logic [3:0]         clamp;
    logic [15:0]        fld [4];
    logic [ACC_W:0]     x [4], sh [4], lv [4], a [4], s [4];
    logic signed [ACC_W:0] sv [4];
    logic [5:0]         w;
    logic               accept;

    function automatic logic [2:0] lanes_of(input logic [3:0] c);
        return (c == 4'b1010) ? 3'd1 : (c == 4'b1001 || c == 4'b0110) ? 3'd2 : 3'd4;
    endfunction

    function automatic logic legal(input logic [3:0] c);
        return c inside {4'b1010, 4'b1001, 4'b0110, 4'b1000, 4'b0010,
                         4'b0101, 4'b0100, 4'b0001, 4'b0000};
    endfunction

    assign accept    = (state == ACCUM) && in_valid;
    assign in_ready  = (state == ACCUM);
    assign res_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign res_data  = {acc[3], acc[2], acc[1], acc[0]};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic; a start seen outside IDLE never leaves a mark
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (len == '0) ? DONE : ACCUM;
            ACCUM:   if (accept && cnt == len_r - 1'b1) state_next = DONE;
            DONE:    if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Lane extraction, sign/zero extension by field width, and clamped add per lane
    always_comb begin
        w = (cfg == 4'b1010) ? 6'd16 : (res_lanes == 3'd2) ? 6'd12 :
            (cfg == 4'b1000 || cfg == 4'b0010) ? 6'd10 : 6'd16;
        for (int k = 0; k < 4; k++) begin
            fld[k]   = (k == 1 && res_lanes == 3'd2) ? in_data[47:32] : in_data[16*k +: 16];
            x[k]     = {fld[k], {(ACC_W-15){1'b0}}};
            sh[k]    = x[k] << (6'd16 - w);
            sv[k]    = $signed(sh[k]) >>> (ACC_W + 1 - int'(w));
            lv[k]    = sgn_r ? sv[k] : sh[k] >> (ACC_W + 1 - int'(w));
            lv[k]    = (legal_r && k < int'(res_lanes)) ? lv[k] : '0;
            a[k]     = {sgn_r & acc[k][ACC_W-1], acc[k]};
            s[k]     = a[k] + lv[k];
            clamp[k] = sgn_r ? (s[k][ACC_W] ^ s[k][ACC_W-1]) : s[k][ACC_W];
            sum[k]   = !clamp[k] ? s[k][ACC_W-1:0] :
                       !sgn_r ? {ACC_W{1'b1}} :
                       s[k][ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    // Job setup on start, accumulation on each accepted beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg       <= '0;
            sgn_r     <= 1'b0;
            legal_r   <= 1'b0;
            len_r     <= '0;
            cnt       <= '0;
            acc       <= '{default: '0};
            res_lanes <= 3'd1;
            sat_flag  <= 1'b0;
        end else if (state == IDLE && start) begin
            cfg       <= {cfga, cfgb};
            sgn_r     <= sgn;
            legal_r   <= legal({cfga, cfgb});
            len_r     <= len;
            cnt       <= '0;
            acc       <= '{default: '0};
            res_lanes <= lanes_of({cfga, cfgb});
            sat_flag  <= !legal({cfga, cfgb});
        end else if (accept) begin
            cnt       <= cnt + 1'b1;
            acc       <= sum;
            sat_flag  <= sat_flag | (|clamp);
        end
    end
endmodule
